// File: rtl/axis_byte_fifo.sv
// rtl/axis_byte_fifo.sv - synchronous 8-bit AXI4-Stream byte FIFO with tlast, fill level and packet count
//
// Purpose:
//   Absorbs bursts from a stream source and feeds an 8-bit stream slave.
//   Each entry stores {tlast, tdata}. In the default build the read side
//   is cut-through (valid whenever not empty). Defining the macro
//   AXIS_BYTE_FIFO_PKT_MODE_EN selects store-and-forward: the read side
//   waits until a whole packet is stored, or until the FIFO is full.
//
// Parameters:
//   DEPTH_LOG2      log2 of the entry count (2..8), DEPTH = 2**DEPTH_LOG2
//
// Ports:
//   clk             sole clock, rising edge
//   rstn            asynchronous active-low reset
//   axis4_s_tdata   write-side byte
//   axis4_s_tvalid  write-side valid
//   axis4_s_tlast   write-side last beat of packet
//   axis4_s_tready  write-side ready (not full)
//   axis4_m_tdata   read-side byte at the read pointer
//   axis4_m_tvalid  read-side valid
//   axis4_m_tlast   tlast stored with the entry at the read pointer
//   axis4_m_tready  read-side ready
//   fifo_level      entries stored, 0..DEPTH
//   pkt_count       stored entries carrying tlast=1, 0..DEPTH
module axis_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            axis4_s_tdata,
  input  logic                  axis4_s_tvalid,
  input  logic                  axis4_s_tlast,
  output logic                  axis4_s_tready,
  output logic [7:0]            axis4_m_tdata,
  output logic                  axis4_m_tvalid,
  output logic                  axis4_m_tlast,
  input  logic                  axis4_m_tready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [DEPTH_LOG2:0]   pkt_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [8:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DEPTH_LOG2:0]   pkt_q, pkt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic rd_last;
  logic m_valid;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign rd_last = mem_q[rd_ptr_q][8];

`ifdef AXIS_BYTE_FIFO_PKT_MODE_EN
  // Store-and-forward. Releasing at full with no stored tlast keeps a
  // packet longer than the FIFO from deadlocking; once a pop frees a slot
  // valid drops again until the FIFO refills or a tlast lands.
  assign m_valid = ~empty & ((pkt_q != '0) | full);
`else
  assign m_valid = ~empty;
`endif

  assign push = axis4_s_tvalid & ~full;
  assign pop  = m_valid & axis4_m_tready;

  assign axis4_s_tready = ~full;
  assign axis4_m_tvalid = m_valid;
  assign axis4_m_tdata  = mem_q[rd_ptr_q][7:0];
  assign axis4_m_tlast  = rd_last;
  assign fifo_level     = level_q;
  assign pkt_count      = pkt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    case ({push & axis4_s_tlast, pop & rd_last})
      2'b10:   pkt_d = pkt_q + LVL_ONE;
      2'b01:   pkt_d = pkt_q - LVL_ONE;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
    end
  end

  // Storage is deliberately left out of reset; stale entries are never
  // visible because valid is gated by the level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {axis4_s_tlast, axis4_s_tdata};
  end

endmodule

// File: tb/tb_axis_byte_fifo.sv
// tb/tb_axis_byte_fifo.sv - scoreboard testbench for axis_byte_fifo
module tb_axis_byte_fifo;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready = 1'b0;
  logic [4:0] fifo_level;
  logic [4:0] pkt_count;

  int n_cmp = 0;
  int n_err = 0;
  int out_cnt = 0;
  logic [8:0] expq[$];

  always #5 clk = ~clk;

  axis_byte_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rstn(rstn),
    .axis4_s_tdata(s_tdata), .axis4_s_tvalid(s_tvalid),
    .axis4_s_tlast(s_tlast), .axis4_s_tready(s_tready),
    .axis4_m_tdata(m_tdata), .axis4_m_tvalid(m_tvalid),
    .axis4_m_tlast(m_tlast), .axis4_m_tready(m_tready),
    .fifo_level(fifo_level), .pkt_count(pkt_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && fifo_level != 0; c++) step();
    chk(name, int'(fifo_level), 0);
  endtask

  // Stimulus-side capture: every byte the source hands over becomes an
  // expected output in order.
  always @(negedge clk) begin
    if (rstn && s_tvalid && s_tready) expq.push_back({s_tlast, s_tdata});
  end

  // Output monitor: compare each beat taken by the sink.
  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      out_cnt++;
      if (expq.size() == 0) begin
        chk("unexpected_beat", int'({m_tlast, m_tdata}), -1);
      end else begin
        chk("beat", int'({m_tlast, m_tdata}), int'(expq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    bit  acc;
    bit  seen;
    int  exp_total;

    // Reset state
    #2;
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_pkt", int'(pkt_count), 0);
    chk("rst_mvalid", int'(m_tvalid), 0);
    chk("rst_sready", int'(s_tready), 1);
    #10 rstn = 1'b1;
    step();

    // Fill to DEPTH with the sink stalled, then drain in order
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(i); s_tlast = (i == 15);
      if (i == 15) chk("fill_sready_before_last", int'(s_tready), 1);
      step();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("fill_sready", int'(s_tready), 0);
    chk("fill_level", int'(fifo_level), 16);
    chk("fill_pkt", int'(pkt_count), 1);
    chk("fill_mvalid", int'(m_tvalid), 1);
    m_tready = 1'b1;
    step();
    chk("first_pop_sready", int'(s_tready), 1);
    chk("first_pop_level", int'(fifo_level), 15);
    drain("fill_drain");
    chk("fill_pkt_end", int'(pkt_count), 0);
    m_tready = 1'b0;
    step();

`ifndef AXIS_BYTE_FIFO_PKT_MODE_EN
    // Streaming: one byte per cycle, level stays at one
    m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(i + 8'h10); s_tlast = 1'b0;
      step();
      chk("stream_level", int'(fifo_level), 1);
      if (i == 0) chk("stream_latency", int'(m_tvalid), 1);
    end
    s_tvalid = 1'b0;
    step();
    chk("stream_end_level", int'(fifo_level), 0);
    m_tready = 1'b0;
    step();
`endif

    // Wrap / simultaneous at full
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h40 + i); s_tlast = 1'b0;
      step();
    end
    chk("wrap_full_level", int'(fifo_level), 16);
    m_tready = 1'b1;
    sent = 0;
    for (int c = 0; c < 300 && sent < 40; c++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h80 + sent); s_tlast = (sent == 39);
      acc = s_tready;
      if (fifo_level == 16) begin
        step();
        chk("full_no_push", int'(fifo_level), 15);
      end else begin
        step();
      end
      if (fifo_level > 16) chk("level_overflow", int'(fifo_level), 16);
      if (acc) sent++;
    end
    chk("wrap_sent", sent, 40);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain("wrap_drain");
    m_tready = 1'b0;
    step();

`ifdef AXIS_BYTE_FIFO_PKT_MODE_EN
    // Short packet held until tlast stored
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'hA1; s_tlast = 1'b0;
    step();
    chk("pkt_hold1", int'(m_tvalid), 0);
    s_tdata = 8'hA2;
    step();
    chk("pkt_hold2", int'(m_tvalid), 0);
    s_tdata = 8'hA3; s_tlast = 1'b1;
    step();
    chk("pkt_release", int'(m_tvalid), 1);
    chk("pkt_count1", int'(pkt_count), 1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain("pkt_drain");
    chk("pkt_count0", int'(pkt_count), 0);

    // Oversize packet released at full
    sent = 0; seen = 1'b0;
    for (int c = 0; c < 300 && sent < 20; c++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'hC0 + sent); s_tlast = (sent == 19);
      acc = s_tready;
      step();
      if (acc) sent++;
      if (m_tvalid && !seen) begin
        seen = 1'b1;
        chk("oversize_first_valid_level", int'(fifo_level), 16);
      end
    end
    chk("oversize_sent", sent, 20);
    chk("oversize_seen", int'(seen), 1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain("oversize_drain");
    m_tready = 1'b0;
    step();
`endif

    // Reset mid-operation
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h20 + i); s_tlast = (i == 2 || i == 6);
      step();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("pre_rst_level", int'(fifo_level), 7);
    chk("pre_rst_pkt", int'(pkt_count), 2);
    #2;
    rstn = 1'b0;
    expq.delete();
    #1;
    chk("mid_rst_mvalid", int'(m_tvalid), 0);
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_pkt", int'(pkt_count), 0);
    chk("mid_rst_sready", int'(s_tready), 1);
    #1 rstn = 1'b1;
    step();
    s_tvalid = 1'b1; s_tdata = 8'h5A; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("post_rst_mvalid", int'(m_tvalid), 1);
    chk("post_rst_data", int'(m_tdata), 8'h5A);
    m_tready = 1'b1;
    drain("post_rst_drain");
    m_tready = 1'b0;
    step();

`ifdef AXIS_BYTE_FIFO_PKT_MODE_EN
    exp_total = 16 + 56 + 3 + 20 + 1;
`else
    exp_total = 16 + 100 + 56 + 1;
`endif
    chk("total_beats", out_cnt, exp_total);
    chk("queue_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
